// File: rtl/out_register.sv
// Wide-result output register: captures a C_NUM_BITS value in one cycle and
// streams it out as 32-bit words, least-significant word first.
//
//   state | meaning
//   IDLE  | empty, waiting for din_valid; din_ready high
//   SEND  | holding a value, presenting word[count] with dout_valid high
module out_register #(
    parameter int C_NUM_BITS = 32
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [C_NUM_BITS-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [31:0]           dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last,
    output logic                  busy
);

    localparam int C_NUM_WORDS  = (C_NUM_BITS + 31) / 32;
    localparam int C_UPPER_BITS = C_NUM_BITS - 32 * (C_NUM_WORDS - 1);
    localparam int CNT_W        = $clog2(C_NUM_WORDS) + 1;
    localparam int PAD_BITS     = 32 * C_NUM_WORDS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(C_NUM_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      count, count_nxt;
    logic [C_NUM_BITS-1:0] held, held_nxt;
    logic [PAD_BITS-1:0]   held_pad;
    logic [31:0]           dout_word;
    logic                  is_last;
    logic                  word_acc;
    logic                  load;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            count <= '0;
            held  <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            held  <= held_nxt;
        end
    end

    // Zero-extend so the final word carries only C_UPPER_BITS live bits.
    always_comb begin
        held_pad                   = '0;
        held_pad[C_NUM_BITS-1:0]   = held;
        dout_word                  = '0;
        for (int i = 0; i < C_NUM_WORDS; i++) begin
            if (count == CNT_W'(i)) begin
                dout_word = held_pad[32*i +: 32];
            end
        end
    end

    assign dout_valid = (state == SEND);
    assign busy       = (state == SEND);
    assign is_last    = (state == SEND) && (count == LAST_CNT);
    assign dout_last  = is_last;
    assign dout       = (state == SEND) ? dout_word : 32'h0;
    assign word_acc   = (state == SEND) && dout_ready;

    // Capture is allowed on the same edge the final word leaves, giving
    // back-to-back values with no bubble; held low throughout reset.
    assign din_ready  = aresetn && ((state == IDLE) || (word_acc && is_last));
    assign load       = din_valid && din_ready;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        held_nxt  = held;
        if (load) begin
            state_nxt = SEND;
            count_nxt = '0;
            held_nxt  = din;
        end else if (word_acc) begin
            if (is_last) begin
                state_nxt = IDLE;
                count_nxt = '0;
            end else begin
                count_nxt = count + 1'b1;
            end
        end
    end

    // C_UPPER_BITS documents the live width of the final word; the zero
    // padding above is what actually enforces it.
    logic upper_bits_ok;
    assign upper_bits_ok = (C_UPPER_BITS >= 1);

    logic unused_ok;
    assign unused_ok = upper_bits_ok;

endmodule

// File: tb/tb_out_register.sv
// Scoreboard bench for out_register: a 72-bit (three words, partial top word)
// and a 32-bit (single word) instance driven with directed and random traffic.
module tb_out_register;

    logic        clk = 1'b0;
    logic        aresetn = 1'b1;

    logic [71:0] a_din = '0;
    logic        a_din_valid = 1'b0;
    logic        a_din_ready;
    logic [31:0] a_dout;
    logic        a_dout_valid;
    logic        a_dout_ready = 1'b0;
    logic        a_dout_last;
    logic        a_busy;

    logic [31:0] b_din = '0;
    logic        b_din_valid = 1'b0;
    logic        b_din_ready;
    logic [31:0] b_dout;
    logic        b_dout_valid;
    logic        b_dout_ready = 1'b0;
    logic        b_dout_last;
    logic        b_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    word_t qa[$];
    word_t qb[$];

    always #5 clk = ~clk;

    out_register #(.C_NUM_BITS(72)) dut_a (
        .clk(clk), .aresetn(aresetn),
        .din(a_din), .din_valid(a_din_valid), .din_ready(a_din_ready),
        .dout(a_dout), .dout_valid(a_dout_valid), .dout_ready(a_dout_ready),
        .dout_last(a_dout_last), .busy(a_busy)
    );

    out_register #(.C_NUM_BITS(32)) dut_b (
        .clk(clk), .aresetn(aresetn),
        .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
        .dout(b_dout), .dout_valid(b_dout_valid), .dout_ready(b_dout_ready),
        .dout_last(b_dout_last), .busy(b_busy)
    );

    task automatic check(input string nm,
                         input logic [31:0] ed, input logic ev, input logic el,
                         input logic er, input logic eb,
                         input logic [31:0] ad, input logic av, input logic al,
                         input logic ar, input logic ab);
        checks++;
        if ({ed, ev, el, er, eb} !== {ad, av, al, ar, ab}) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s t=%0t: got dout=%h valid=%b last=%b din_ready=%b busy=%b, expected dout=%h valid=%b last=%b din_ready=%b busy=%b",
                         nm, $time, ad, av, al, ar, ab, ed, ev, el, er, eb);
        end
    endtask

    // Reference: a value accepted on an edge becomes a list of words; the head
    // of the list is what must be on dout, and the port is empty when it is.
    always @(negedge clk) begin
        word_t w;
        logic  exp_rdy;
        if (!aresetn) begin
            qa.delete();
            check("a_reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                  a_dout, a_dout_valid, a_dout_last, a_din_ready, a_busy);
        end else begin
            exp_rdy = (qa.size() == 0) || (a_dout_ready && qa.size() == 1);
            if (qa.size() != 0)
                check("a_word", qa[0].data, 1'b1, qa[0].last, exp_rdy, 1'b1,
                      a_dout, a_dout_valid, a_dout_last, a_din_ready, a_busy);
            else
                check("a_idle", 32'h0, 1'b0, 1'b0, exp_rdy, 1'b0,
                      a_dout, a_dout_valid, a_dout_last, a_din_ready, a_busy);
            if (qa.size() != 0 && a_dout_ready) void'(qa.pop_front());
            if (a_din_valid && exp_rdy) begin
                for (int i = 0; i < 3; i++) begin
                    w.data = 32'(a_din >> (32 * i));
                    w.last = (i == 2);
                    qa.push_back(w);
                end
            end
        end
    end

    always @(negedge clk) begin
        word_t w;
        logic  exp_rdy;
        if (!aresetn) begin
            qb.delete();
            check("b_reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                  b_dout, b_dout_valid, b_dout_last, b_din_ready, b_busy);
        end else begin
            exp_rdy = (qb.size() == 0) || (b_dout_ready && qb.size() == 1);
            if (qb.size() != 0)
                check("b_word", qb[0].data, 1'b1, qb[0].last, exp_rdy, 1'b1,
                      b_dout, b_dout_valid, b_dout_last, b_din_ready, b_busy);
            else
                check("b_idle", 32'h0, 1'b0, 1'b0, exp_rdy, 1'b0,
                      b_dout, b_dout_valid, b_dout_last, b_din_ready, b_busy);
            if (qb.size() != 0 && b_dout_ready) void'(qb.pop_front());
            if (b_din_valid && exp_rdy) begin
                w.data = b_din;
                w.last = 1'b1;
                qb.push_back(w);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs(input int valid_pct, input int ready_pct);
        a_din        = {8'($urandom), $urandom, $urandom};
        a_din_valid  = ($urandom_range(99) < valid_pct);
        a_dout_ready = ($urandom_range(99) < ready_pct);
        b_din        = $urandom;
        b_din_valid  = ($urandom_range(99) < valid_pct);
        b_dout_ready = ($urandom_range(99) < ready_pct);
    endtask

    initial begin
        #1 aresetn = 1'b0;
        repeat (3) step();
        aresetn = 1'b1;
        step();

        // Three-word value streamed with the consumer always ready.
        a_din = 72'hAB_1122334455667788;
        a_din_valid = 1'b1;
        a_dout_ready = 1'b1;
        step();
        a_din_valid = 1'b0;
        repeat (5) step();

        // Same value with the consumer stalling every other cycle.
        a_din_valid = 1'b1;
        step();
        a_din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_dout_ready = (i % 2 == 0);
            step();
        end
        a_dout_ready = 1'b1;
        repeat (3) step();

        // Single-word value, first without then with consumer ready.
        b_din = 32'hDEADBEEF;
        b_din_valid = 1'b1;
        b_dout_ready = 1'b0;
        step();
        b_din_valid = 1'b0;
        repeat (2) step();
        b_dout_ready = 1'b1;
        repeat (2) step();

        // Offers during SEND must be ignored until the final word leaves.
        a_din = 72'h5A_CAFEF00D_12345678;
        a_din_valid = 1'b1;
        step();
        a_din = 72'hFF_FFFFFFFF_FFFFFFFF;
        a_dout_ready = 1'b0;
        repeat (3) step();
        a_din_valid = 1'b0;
        a_dout_ready = 1'b1;
        repeat (4) step();

        // Back-to-back: valid held high and consumer always ready.
        for (int i = 0; i < 60; i++) begin
            randomize_inputs(100, 100);
            step();
        end

        // Reset in the middle of a transfer, after word 1 is accepted.
        a_din = 72'h77_99887766_55443322;
        a_din_valid = 1'b1;
        a_dout_ready = 1'b1;
        b_din_valid = 1'b0;
        step();
        a_din_valid = 1'b0;
        repeat (2) step();
        aresetn = 1'b0;
        repeat (2) step();
        aresetn = 1'b1;
        step();
        a_din = 72'h01_02030405_06070809;
        a_din_valid = 1'b1;
        step();
        a_din_valid = 1'b0;
        repeat (4) step();

        // Random traffic with stalls.
        for (int i = 0; i < 2000; i++) begin
            randomize_inputs(50, 70);
            step();
        end

        a_din_valid = 1'b0;
        b_din_valid = 1'b0;
        a_dout_ready = 1'b1;
        b_dout_ready = 1'b1;
        repeat (8) step();
        @(negedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: words left a=%0d b=%0d, expected 0 and 0", qa.size(), qb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
